temp_sense_scheduler: RTL and testbench

Sequences the on-die temperature sensor (ALTTEMP-style, ce/clr/done/8-bit ADC) and shares it between NREQ requesters plus a periodic background refresh. It drives ce/clr, bounds each conversion with a timeout and converts the ADC code to signed °C. It returns one result to all requesters batched into that conversion. It sits between the sensor megafunction instance and fan-control/monitoring clients in the clk50 domain.

---
 rtl/temp_sense_scheduler_if.sv | 23 ++
 rtl/temp_sense_scheduler.sv | 145 ++++++++++++++
 tb/tb_temp_sense_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/temp_sense_scheduler_if.sv
// Client-side bundle of the temperature sense scheduler: request pulses in,
// per-requester ack plus the shared conversion result and status out.
interface temp_sense_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    ack;
  logic signed [7:0]  result;
  logic               result_err;
  logic signed [7:0]  last_temp;
  logic               last_valid;
  logic               busy;

  modport master (
    output req,
    input  ack, result, result_err, last_temp, last_valid, busy
  );

  modport slave (
    input  req,
    output ack, result, result_err, last_temp, last_valid, busy
  );
endinterface

// File: rtl/temp_sense_scheduler.sv
// Shares one on-die temperature sensor between NREQ requesters and a periodic
// background refresh; batches requests into conversions and returns signed degC.
module temp_sense_scheduler #(
  parameter int NREQ       = 4,
  parameter int CLR_CYCLES = 4,
  parameter int TIMEOUT    = 200000,
  parameter int PERIOD     = 1048575,
  parameter int IDLE_GAP   = 16
) (
  input  logic                  clk50,
  input  logic                  rstn,
  temp_sense_scheduler_if.slave bus,
  output logic                  temp_ce,
  output logic                  temp_clr,
  input  logic                  tsdcaldone,
  input  logic [7:0]            tsdcalo
);

  localparam int MAX_A   = (CLR_CYCLES > IDLE_GAP) ? CLR_CYCLES : IDLE_GAP;
  localparam int CNT_MAX = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BG_W    = $clog2(PERIOD + 1);

  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IDLE_GAP - 1);
  localparam logic [BG_W-1:0]  BG_FULL  = BG_W'(PERIOD);

  localparam logic signed [7:0] ERR_RESULT = 8'sh80;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_CONVERT = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  // ADC code is offset-binary around 128 = 0 degC.
  function automatic logic signed [7:0] f_code_to_degc(input logic [7:0] code);
    return $signed(code - 8'd128);
  endfunction

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BG_W-1:0]   r_bg;
  logic [NREQ-1:0]   r_pending;
  logic [NREQ-1:0]   r_served;
  logic [NREQ-1:0]   r_ack;
  logic signed [7:0] r_result;
  logic              r_err;
  logic signed [7:0] r_last_temp;
  logic              r_last_valid;

  logic              w_start;
  logic [NREQ-1:0]   w_clear_mask;

  assign w_start      = (r_state == S_IDLE) && ((r_pending != '0) || (r_bg == BG_FULL));
  assign w_clear_mask = w_start ? r_pending : '0;

  // Requests arriving on the start edge stay pending for the next batch.
  always_ff @(posedge clk50 or negedge rstn) begin
    if (!rstn) begin
      r_pending <= '0;
      r_bg      <= BG_FULL;
    end else begin
      r_pending <= (r_pending & ~w_clear_mask) | bus.req;
      if (w_start)
        r_bg <= '0;
      else if (r_bg != BG_FULL)
        r_bg <= r_bg + BG_W'(1);
    end
  end

  always_ff @(posedge clk50 or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_served     <= '0;
      r_ack        <= '0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_last_temp  <= '0;
      r_last_valid <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_served <= r_pending;
            r_cnt    <= '0;
            r_state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_cnt == CLR_LAST) begin
            r_cnt   <= '0;
            r_state <= S_CONVERT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CONVERT: begin
          // A done on the last timeout cycle still counts as a good reading.
          if (tsdcaldone) begin
            r_ack        <= r_served;
            r_result     <= f_code_to_degc(tsdcalo);
            r_err        <= 1'b0;
            r_last_temp  <= f_code_to_degc(tsdcalo);
            r_last_valid <= 1'b1;
            r_state      <= S_DONE;
          end else if (r_cnt == TO_LAST) begin
            r_ack    <= r_served;
            r_result <= ERR_RESULT;
            r_err    <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_cnt   <= '0;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign temp_ce        = (r_state == S_CLEAR) || (r_state == S_CONVERT);
  assign temp_clr       = (r_state == S_CLEAR);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.ack        = r_ack;
  assign bus.result     = r_result;
  assign bus.result_err = r_err;
  assign bus.last_temp  = r_last_temp;
  assign bus.last_valid = r_last_valid;

endmodule

// File: tb/tb_temp_sense_scheduler.sv
// Directed bench for temp_sense_scheduler: table of single-batch conversions
// plus hand-written sequences for background, overlap and reset corners.
module tb_temp_sense_scheduler;

  localparam int NREQ = 4;
  localparam int CLRC = 4;
  localparam int TO   = 100;
  localparam int PER  = 5000;
  localparam int GAP  = 16;

  logic       clk50 = 1'b0;
  logic       rstn  = 1'b0;
  logic       temp_ce;
  logic       temp_clr;
  logic       tsdcaldone = 1'b0;
  logic [7:0] tsdcalo    = 8'd0;

  temp_sense_scheduler_if #(.NREQ(NREQ)) u_if ();

  temp_sense_scheduler #(
    .NREQ(NREQ), .CLR_CYCLES(CLRC), .TIMEOUT(TO), .PERIOD(PER), .IDLE_GAP(GAP)
  ) u_dut (
    .clk50      (clk50),
    .rstn       (rstn),
    .bus        (u_if.slave),
    .temp_ce    (temp_ce),
    .temp_clr   (temp_clr),
    .tsdcaldone (tsdcaldone),
    .tsdcalo    (tsdcalo)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    logic [3:0] req;
    int         dly;
    bit         pulse;
    logic [7:0] code;
    logic [3:0] e_ack;
    int         e_res;
    bit         e_err;
    int         e_last;
  } vec_t;

  vec_t vt[6];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!u_if.busy) break;
      @(negedge clk50);
    end
    chk("wait_idle", {31'd0, u_if.busy}, 0);
  endtask

  task automatic pulse_req(input logic [3:0] m);
    u_if.req = m;
    @(negedge clk50);
    u_if.req = '0;
  endtask

  // Polls until the first CONVERT cycle, counting clr cycles and any ack seen.
  task automatic wait_convert(output int nclr, output int nack);
    bit found;
    found = 1'b0;
    nclr  = 0;
    nack  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk50);
      if (temp_ce && !temp_clr) begin
        found = 1'b1;
        break;
      end
      if (temp_clr) nclr++;
      if (u_if.ack != '0) nack++;
    end
    chk("reach_convert", {31'd0, found}, 1);
  endtask

  // Called in CONVERT cycle 1; drives done (if p) in CONVERT cycle d, returns in DONE.
  task automatic finish_conv(input int d, input bit p, input logic [7:0] code);
    repeat (d - 1) @(negedge clk50);
    tsdcaldone = p;
    tsdcalo    = code;
    @(negedge clk50);
    tsdcaldone = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},   {28'd0, u_if.ack}, 0);
    chk({tag, "_res"},   u_if.result, 0);
    chk({tag, "_err"},   {31'd0, u_if.result_err}, 0);
    chk({tag, "_last"},  u_if.last_temp, 0);
    chk({tag, "_valid"}, {31'd0, u_if.last_valid}, 0);
    chk({tag, "_busy"},  {31'd0, u_if.busy}, 0);
    chk({tag, "_ce"},    {31'd0, temp_ce}, 0);
    chk({tag, "_clr"},   {31'd0, temp_clr}, 0);
  endtask

  initial begin
    int nclr, nack, g, ce_bad;
    u_if.req = '0;

    vt[0] = '{4'b1000, TO,  1'b0, 8'd0,   4'b1000, -128, 1'b1, 40};
    vt[1] = '{4'b0101, 10,  1'b1, 8'd100, 4'b0101, -28,  1'b0, -28};
    vt[2] = '{4'b0010, TO,  1'b1, 8'd128, 4'b0010, 0,    1'b0, 0};
    vt[3] = '{4'b1111, 1,   1'b1, 8'd255, 4'b1111, 127,  1'b0, 127};
    vt[4] = '{4'b0001, 3,   1'b1, 8'd0,   4'b0001, -128, 1'b0, -128};
    vt[5] = '{4'b0100, 20,  1'b1, 8'd1,   4'b0100, -127, 1'b0, -127};

    // Reset state, then the post-reset background conversion.
    repeat (3) @(negedge clk50);
    chk_reset_vals("rst0");
    rstn = 1'b1;
    wait_convert(nclr, nack);
    chk("bg_clr_cycles", nclr, CLRC);
    finish_conv(50, 1'b1, 8'd168);
    chk("bg_ack", {28'd0, u_if.ack}, 0);
    chk("bg_last", u_if.last_temp, 40);
    chk("bg_valid", {31'd0, u_if.last_valid}, 1);
    chk("bg_done_ce", {31'd0, temp_ce}, 0);
    chk("bg_nack", nack, 0);
    g = 0;
    ce_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk50);
      if (!u_if.busy) break;
      if (temp_ce) ce_bad++;
      if (u_if.ack != '0) ce_bad++;
      g++;
    end
    chk("bg_gap_len", g, GAP);
    chk("bg_gap_ce", ce_bad, 0);

    // Table of single-batch transactions.
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      pulse_req(vt[i].req);
      wait_convert(nclr, nack);
      finish_conv(vt[i].dly, vt[i].pulse, vt[i].code);
      chk($sformatf("v%0d_ack", i),   {28'd0, u_if.ack}, {28'd0, vt[i].e_ack});
      chk($sformatf("v%0d_res", i),   u_if.result, vt[i].e_res);
      chk($sformatf("v%0d_err", i),   {31'd0, u_if.result_err}, {31'd0, vt[i].e_err});
      chk($sformatf("v%0d_last", i),  u_if.last_temp, vt[i].e_last);
      chk($sformatf("v%0d_valid", i), {31'd0, u_if.last_valid}, 1);
      @(negedge clk50);
      chk($sformatf("v%0d_ack_off", i), {28'd0, u_if.ack}, 0);
      chk($sformatf("v%0d_res_hold", i), u_if.result, vt[i].e_res);
    end

    // Second request arriving while the first batch converts.
    wait_idle();
    pulse_req(4'b0001);
    wait_convert(nclr, nack);
    @(negedge clk50);
    u_if.req = 4'b0010;
    @(negedge clk50);
    u_if.req = '0;
    finish_conv(3, 1'b1, 8'd150);
    chk("ovl1_ack", {28'd0, u_if.ack}, 4'b0001);
    chk("ovl1_res", u_if.result, 22);
    wait_convert(nclr, nack);
    chk("ovl2_nack", nack, 0);
    chk("ovl2_clr", nclr, CLRC);
    finish_conv(2, 1'b1, 8'd130);
    chk("ovl2_ack", {28'd0, u_if.ack}, 4'b0010);
    chk("ovl2_res", u_if.result, 2);

    // Reset mid-CONVERT drops the pending requester and restarts in background.
    wait_idle();
    pulse_req(4'b0100);
    wait_convert(nclr, nack);
    repeat (5) @(negedge clk50);
    rstn = 1'b0;
    repeat (3) @(negedge clk50);
    chk_reset_vals("rst1");
    rstn = 1'b1;
    @(negedge clk50);
    chk("rst1_restart_busy", {31'd0, u_if.busy}, 1);
    chk("rst1_restart_clr", {31'd0, temp_clr}, 1);
    wait_convert(nclr, nack);
    chk("rst1_clr", nclr, CLRC - 1);
    finish_conv(7, 1'b1, 8'd200);
    chk("rst1_ack", {28'd0, u_if.ack}, 0);
    chk("rst1_last", u_if.last_temp, 72);
    chk("rst1_valid", {31'd0, u_if.last_valid}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
